// File: rtl/quad_step_decoder_pkg.sv
// Shared definitions for the quadrature step decoder.
//   quad_state_e : control FSM states (PRIME while settling after reset, TRACK while decoding)
//   FWD_FROM_xx  : the {a,b} level that follows xx when the shaft turns forward (up)
//   fwd_next()   : looks up the forward successor of an {a,b} pair
//   acc_width()  : signed accumulator width for a given quarter-steps-per-step divider
package quad_pkg;

  typedef enum logic {
    PRIME = 1'b0,
    TRACK = 1'b1
  } quad_state_e;

  // Forward rotation walks the Gray ring 00 -> 01 -> 11 -> 10 -> 00.
  localparam logic [1:0] FWD_FROM_00 = 2'b01;
  localparam logic [1:0] FWD_FROM_01 = 2'b11;
  localparam logic [1:0] FWD_FROM_11 = 2'b10;
  localparam logic [1:0] FWD_FROM_10 = 2'b00;

  function automatic logic [1:0] fwd_next(input logic [1:0] ab);
    logic [1:0] nxt;
    case (ab)
      2'b00:   nxt = FWD_FROM_00;
      2'b01:   nxt = FWD_FROM_01;
      2'b11:   nxt = FWD_FROM_11;
      default: nxt = FWD_FROM_10;
    endcase
    return nxt;
  endfunction

  // One sign bit plus enough magnitude bits to hold +/-(div-1).
  function automatic int acc_width(input int div);
    return $clog2(div) + 1;
  endfunction

endpackage

// File: rtl/quad_step_decoder_if.sv
// Signal bundle between the encoder side and the decoder.
//   quad_a, quad_b : raw encoder channels, asynchronous to clk
//   err_clr        : clears the sticky error flag
//   enable         : one-cycle step strobe; no back-pressure, the consumer must take it
//   upDown         : step direction (1 = up), valid with enable and held between strobes
//   err            : sticky illegal-transition flag
// The master modport drives the encoder inputs; the slave modport is the decoder.
interface quad_step_decoder_if;
  import quad_pkg::*;

  logic quad_a;
  logic quad_b;
  logic err_clr;
  logic enable;
  logic upDown;
  logic err;

  modport master (
    output quad_a, quad_b, err_clr,
    input  enable, upDown, err
  );

  modport slave (
    input  quad_a, quad_b, err_clr,
    output enable, upDown, err
  );

endinterface

// File: rtl/quad_step_decoder_filter.sv
// Per-channel front end: two-flop synchroniser followed by a stability filter.
//   clk, rst : system clock, synchronous active-high reset
//   i_raw    : asynchronous channel input
//   i_load   : forces the filtered level to the current synchronised level
//   o_sync   : synchronised level (second flop)
//   o_filt   : filtered level; changes only after FILTER_LEN consecutive mismatches
module quad_filter
  import quad_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  input  logic i_load,
  output logic o_sync,
  output logic o_filt
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_filt;
  logic [CNT_W-1:0] r_cnt;

  // The synchroniser keeps sampling through reset so that the PRIME load
  // right after reset release sees the true channel level.
  always_ff @(posedge clk) begin
    r_sync1 <= i_raw;
    r_sync2 <= r_sync1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_filt <= r_sync2;
      r_cnt  <= '0;
    end else if (r_sync2 != r_filt) begin
      // r_cnt holds the mismatches already seen; this one is number r_cnt+1.
      if (r_cnt == CNT_LAST) begin
        r_filt <= r_sync2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_sync = r_sync2;
  assign o_filt = r_filt;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature encoder to step-pulse decoder.
//   clk, rst    : system clock, synchronous active-high reset
//   bus (slave) : quad_a/quad_b/err_clr in, enable/upDown/err out (registered)
//   o_dbg_state : control FSM state
//   o_dbg_acc   : signed quarter-step accumulator
//   o_dbg_filt  : filtered {a,b}
// Parameters: FILTER_LEN (1..16) stability cycles per channel, DIV (1,2,4)
// quarter-steps per output step.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter  int FILTER_LEN = 4,
  parameter  int DIV        = 4,
  localparam int ACC_W      = acc_width(DIV)
) (
  input  logic                    clk,
  input  logic                    rst,
  quad_step_decoder_if.slave      bus,
  output quad_state_e             o_dbg_state,
  output logic signed [ACC_W-1:0] o_dbg_acc,
  output logic [1:0]              o_dbg_filt
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(DIV - 1);
  localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;

  logic w_sync_a, w_sync_b;
  logic w_filt_a, w_filt_b;
  logic w_load;
  logic w_illegal;
  logic [1:0] w_cur;

  quad_state_e             r_state;
  logic                    r_prime_cnt;
  logic [1:0]              r_prev;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_enable;
  logic                    r_up;
  logic                    r_err;

  quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .rst(rst), .i_raw(bus.quad_a), .i_load(w_load),
    .o_sync(w_sync_a), .o_filt(w_filt_a)
  );

  quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .rst(rst), .i_raw(bus.quad_b), .i_load(w_load),
    .o_sync(w_sync_b), .o_filt(w_filt_b)
  );

  assign w_cur     = {w_filt_a, w_filt_b};
  // Second PRIME cycle: filters and previous state take the synced levels together.
  assign w_load    = (r_state == PRIME) && r_prime_cnt;
  // Both channels moving at once means a skipped quarter-step.
  assign w_illegal = (r_state == TRACK) && (w_cur == ~r_prev);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= PRIME;
      r_prime_cnt <= 1'b0;
      r_prev      <= 2'b00;
      r_acc       <= '0;
      r_enable    <= 1'b0;
      r_up        <= 1'b1;
      r_err       <= 1'b0;
    end else begin
      r_enable <= 1'b0;
      case (r_state)
        PRIME: begin
          if (!r_prime_cnt) begin
            r_prime_cnt <= 1'b1;
          end else begin
            r_prime_cnt <= 1'b0;
            r_prev      <= {w_sync_a, w_sync_b};
            r_state     <= TRACK;
          end
        end
        TRACK: begin
          if (w_cur != r_prev) begin
            r_prev <= w_cur;
            if (w_illegal) begin
              r_acc <= '0;
            end else if (w_cur == fwd_next(r_prev)) begin
              if (r_acc == ACC_MAX) begin
                r_enable <= 1'b1;
                r_up     <= 1'b1;
                r_acc    <= '0;
              end else begin
                r_acc <= r_acc + ACC_W'(1);
              end
            end else begin
              if (r_acc == ACC_MIN) begin
                r_enable <= 1'b1;
                r_up     <= 1'b0;
                r_acc    <= '0;
              end else begin
                r_acc <= r_acc - ACC_W'(1);
              end
            end
          end
        end
        default: r_state <= PRIME;
      endcase
      // A new illegal transition wins over a clear in the same cycle.
      if (w_illegal) begin
        r_err <= 1'b1;
      end else if (bus.err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign bus.enable  = r_enable;
  assign bus.upDown  = r_up;
  assign bus.err     = r_err;
  assign o_dbg_state = r_state;
  assign o_dbg_acc   = r_acc;
  assign o_dbg_filt  = w_cur;

endmodule

// File: tb/tb_quad_step_decoder.sv
module tb_quad_step_decoder;
  import quad_pkg::*;

  localparam int FL = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic drv_a, drv_b, drv_clr;

  quad_step_decoder_if bus4();
  quad_step_decoder_if bus1();

  assign bus4.quad_a  = drv_a;
  assign bus4.quad_b  = drv_b;
  assign bus4.err_clr = drv_clr;
  assign bus1.quad_a  = drv_a;
  assign bus1.quad_b  = drv_b;
  assign bus1.err_clr = drv_clr;

  quad_state_e       st4, st1;
  logic signed [2:0] acc4;
  logic signed [0:0] acc1;
  logic [1:0]        filt4, filt1;

  quad_step_decoder #(.FILTER_LEN(FL), .DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4),
    .o_dbg_state(st4), .o_dbg_acc(acc4), .o_dbg_filt(filt4)
  );

  quad_step_decoder #(.FILTER_LEN(FL), .DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .o_dbg_state(st1), .o_dbg_acc(acc1), .o_dbg_filt(filt1)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Inputs seen at each rising edge, newest first. The filter at edge k sees
  // the sample taken two edges earlier, so its window is entries 1..FL.
  logic [1:0] exp_q[$];
  logic [1:0] m_filt, m_prev;
  bit         m_track;
  int         m_pcnt;
  int         m_acc[2];
  bit         m_en[2], m_up[2], m_err[2];

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Position on the forward Gray ring 00,01,11,10.
  function automatic int ring_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ring_ab(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic model_reset();
    m_track = 0; m_pcnt = 0; m_filt = 2'b00; m_prev = 2'b00;
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 0; m_en[i] = 0; m_up[i] = 1; m_err[i] = 0;
    end
  endtask

  task automatic model_step(input logic [1:0] ab, input logic clr, input logic r);
    int d;
    logic [1:0] nf;
    bit all_opp;
    if (r) begin
      model_reset();
    end else if (!m_track) begin
      for (int i = 0; i < 2; i++) begin
        m_en[i] = 0;
        if (clr) m_err[i] = 0;
      end
      if (m_pcnt == 0) m_pcnt = 1;
      else begin
        m_filt  = exp_q[1];
        m_prev  = exp_q[1];
        m_track = 1;
      end
    end else begin
      d = (ring_pos(m_filt) - ring_pos(m_prev) + 4) % 4;
      for (int i = 0; i < 2; i++) begin
        m_en[i] = 0;
        if (d == 1) begin
          m_acc[i] = m_acc[i] + 1;
          if (m_acc[i] == div_of(i)) begin m_en[i] = 1; m_up[i] = 1; m_acc[i] = 0; end
        end else if (d == 3) begin
          m_acc[i] = m_acc[i] - 1;
          if (m_acc[i] == -div_of(i)) begin m_en[i] = 1; m_up[i] = 0; m_acc[i] = 0; end
        end else if (d == 2) begin
          m_acc[i] = 0;
        end
        if (d == 2) m_err[i] = 1;
        else if (clr) m_err[i] = 0;
      end
      if (d != 0) m_prev = m_filt;
      // A channel flips once its last FL filter-visible samples all disagree with it.
      nf = m_filt;
      for (int ch = 0; ch < 2; ch++) begin
        all_opp = 1;
        for (int j = 1; j <= FL; j++)
          if (exp_q[j][ch] == m_filt[ch]) all_opp = 0;
        if (all_opp) nf[ch] = ~m_filt[ch];
      end
      m_filt = nf;
    end
    exp_q.push_front(ab);
    if (exp_q.size() > 24) void'(exp_q.pop_back());
  endtask

  // ---------------- driver ----------------
  int tick_no = 0;
  int pulses4 = 0, ups4 = 0, pulses1 = 0, last_pulse_tick = 0;

  task automatic tick(input logic [1:0] ab, input logic clr, input logic r);
    drv_a = ab[1]; drv_b = ab[0]; drv_clr = clr; rst = r;
    @(posedge clk);
    model_step(ab, clr, r);
    @(negedge clk);
    tick_no++;
    check("en4",  bus4.enable, m_en[0]);
    check("up4",  bus4.upDown, m_up[0]);
    check("err4", bus4.err,    m_err[0]);
    check("acc4", 32'($signed(acc4)), m_acc[0]);
    check("trk4", st4 == TRACK, m_track);
    check("en1",  bus1.enable, m_en[1]);
    check("up1",  bus1.upDown, m_up[1]);
    check("err1", bus1.err,    m_err[1]);
    check("acc1", 32'($signed(acc1)), m_acc[1]);
    check("trk1", st1 == TRACK, m_track);
    if (m_track) begin
      check("filt4", filt4, m_filt);
      check("filt1", filt1, m_filt);
    end
    if (bus4.enable) begin
      pulses4++;
      last_pulse_tick = tick_no;
      if (bus4.upDown) ups4++;
    end
    if (bus1.enable) pulses1++;
  endtask

  task automatic hold(input logic [1:0] ab, input int n);
    repeat (n) tick(ab, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input logic [1:0] ab, input int n);
    repeat (n) tick(ab, 1'b0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int chg;
    int r;
    int len;
    logic [1:0] cur;
    logic [1:0] nxt;
    rst = 1'b1; drv_a = 1'b0; drv_b = 1'b0; drv_clr = 1'b0;
    for (int i = 0; i < 24; i++) exp_q.push_back(2'b00);
    model_reset();
    @(negedge clk);

    // Forward detent
    do_reset(2'b00, 3);
    hold(2'b00, 10);
    pulses4 = 0; ups4 = 0;
    hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10);
    chg = tick_no + 1;
    hold(2'b00, 10);
    check("fwd_pulses", pulses4, 1);
    check("fwd_dir", ups4, 1);
    check("fwd_latency", last_pulse_tick - chg + 1, FL + 3);

    // Reverse detent
    pulses4 = 0; ups4 = 0;
    hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 10);
    check("rev_pulses", pulses4, 1);
    check("rev_dir", ups4, 0);
    hold(2'b00, 20);
    check("rev_dir_held", bus4.upDown, 0);

    // Glitch rejection on A
    pulses4 = 0;
    hold(2'b10, FL - 1); hold(2'b00, 10);
    check("glitch_filt", filt4, 2'b00);
    check("glitch_pulses", pulses4, 0);
    hold(2'b10, FL); hold(2'b00, 3);
    check("accept_filt", filt4, 2'b10);
    // 00 -> 10 is the inverse of the forward step 10 -> 00
    check("accept_acc", 32'($signed(acc4)), -1);
    hold(2'b00, 10);

    // Illegal transitions and err_clr priority
    pulses4 = 0;
    hold(2'b01, 10);
    check("pre_illegal_acc", 32'($signed(acc4)), 1);
    hold(2'b10, 10);
    check("illegal_err", bus4.err, 1);
    check("illegal_acc", 32'($signed(acc4)), 0);
    check("illegal_pulses", pulses4, 0);
    tick(2'b10, 1'b1, 1'b0);
    check("err_clr", bus4.err, 0);
    repeat (FL + 2) tick(2'b01, 1'b0, 1'b0);
    tick(2'b01, 1'b1, 1'b0);
    check("err_set_beats_clr", bus4.err, 1);
    hold(2'b01, 4);
    tick(2'b01, 1'b1, 1'b0);
    hold(2'b01, 2);

    // Mid-detent reversal
    do_reset(2'b00, 3);
    hold(2'b00, 10);
    pulses4 = 0;
    hold(2'b01, 10); hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 10);
    check("rev_mid_pulses", pulses4, 0);
    check("rev_mid_acc", 32'($signed(acc4)), 0);
    pulses4 = 0; pulses1 = 0;
    hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 10);
    check("after_rev_pulses", pulses4, 1);
    check("div1_pulses", pulses1, 4);

    // Reset mid-operation
    hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10);
    check("pre_rst_acc", 32'($signed(acc4)), 3);
    do_reset(2'b11, 4);
    check("rst_en", bus4.enable, 0);
    check("rst_up", bus4.upDown, 1);
    check("rst_err", bus4.err, 0);
    check("rst_acc", 32'($signed(acc4)), 0);
    hold(2'b11, 20);
    check("prime_err", bus4.err, 0);
    check("prime_filt", filt4, 2'b11);
    hold(2'b10, 10);
    check("prime_step_acc", 32'($signed(acc4)), 1);

    // Randomized traffic against the model
    cur = 2'b10;
    for (int it = 0; it < 400; it++) begin
      r   = int'($urandom_range(0, 99));
      len = int'($urandom_range(2, 12));
      if (r < 60) begin
        nxt = ring_ab(ring_pos(cur) + (($urandom_range(0, 1) == 1) ? 1 : 3));
      end else if (r < 70) begin
        nxt = cur ^ (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
        repeat (int'($urandom_range(1, FL - 1))) tick(nxt, 1'b0, 1'b0);
        nxt = cur;
      end else if (r < 78) begin
        nxt = ~cur;
      end else if (r < 81) begin
        do_reset(cur, int'($urandom_range(1, 4)));
        nxt = cur;
      end else begin
        nxt = cur;
      end
      repeat (len) tick(nxt, ($urandom_range(0, 7) == 0), 1'b0);
      cur = nxt;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
